// File: rtl/dm_if.sv
// dm_if: core data-memory request/response bus, directions named from the responder side
interface dm_if #(parameter int XLEN = 32);
    logic            DM_EN_n_i;
    logic            DM_WEN_i;
    logic [XLEN-1:0] DM_addr_i;
    logic [XLEN-1:0] DM_data_i;
    logic [XLEN-1:0] DM_data_o;
    modport master(output DM_EN_n_i, DM_WEN_i, DM_addr_i, DM_data_i, input DM_data_o);
    modport slave(input DM_EN_n_i, DM_WEN_i, DM_addr_i, DM_data_i, output DM_data_o);
endinterface

// File: rtl/dm_responder.sv
// dm_responder: word RAM plus MMIO page (cycle counter, status, tohost halt, console FIFO)
module dm_responder #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int              CON_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    dm_if.slave             dm,
    output logic            con_valid_o,
    output logic [7:0]      con_data_o,
    input  logic            con_ready_i,
    output logic            halt_o,
    output logic [XLEN-1:0] exit_code_o,
    output logic            err_o
);
    localparam int MW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(CON_DEPTH);
    logic [XLEN-1:0] mem_q [DEPTH_WORDS];
    logic [7:0]      con_buf_q [CON_DEPTH];
    logic [XLEN-1:0] cycle_q, cycle_d, exit_q, exit_d, mmio_off;
    logic            halt_q, halt_d, err_q, err_d, ovf_q, ovf_d;
    logic [CW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW:0]     cnt_q, cnt_d;
    logic            en, mmio_hit, ram_hit, bad, wr_ok, ram_we, tohost_we, con_we;
    logic            full, empty, pop, push;
    always_comb begin
        en        = !dm.DM_EN_n_i;
        mmio_off  = dm.DM_addr_i - MMIO_BASE;
        mmio_hit  = mmio_off < XLEN'(16);
        ram_hit   = (dm.DM_addr_i >> 2) < XLEN'(DEPTH_WORDS);
        bad       = en && (dm.DM_addr_i[1:0] != 2'b00 || !(mmio_hit || ram_hit));
        // halted or resetting: every write is dropped, reads are still served
        wr_ok     = en && dm.DM_WEN_i && !bad && !halt_q && !rst;
        ram_we    = wr_ok && !mmio_hit;
        tohost_we = wr_ok && mmio_hit && mmio_off[3:2] == 2'd2;
        con_we    = wr_ok && mmio_hit && mmio_off[3:2] == 2'd3;
        empty     = cnt_q == '0;
        full      = cnt_q == (CW+1)'(CON_DEPTH);
        pop       = !empty && con_ready_i;
        push      = con_we && (!full || pop);
        cycle_d   = halt_q ? cycle_q : cycle_q + XLEN'(1);
        halt_d    = halt_q || tohost_we;
        exit_d    = tohost_we ? dm.DM_data_i : exit_q;
        err_d     = err_q || bad;
        ovf_d     = ovf_q || (con_we && full && !pop);
        rd_ptr_d  = rd_ptr_q + CW'(pop);
        wr_ptr_d  = wr_ptr_q + CW'(push);
        cnt_d     = cnt_q + (CW+1)'(push) - (CW+1)'(pop);
        dm.DM_data_o = (!en || dm.DM_WEN_i || bad) ? '0 :
                       !mmio_hit ? mem_q[dm.DM_addr_i[MW+1:2]] :
                       mmio_off[3:2] == 2'd0 ? cycle_q :
                       mmio_off[3:2] == 2'd1 ? {{(XLEN-3){1'b0}}, ovf_q, full, empty} : '0;
    end
    always_ff @(posedge clk) begin
        if (ram_we) mem_q[dm.DM_addr_i[MW+1:2]] <= dm.DM_data_i;
        if (push) con_buf_q[wr_ptr_q] <= dm.DM_data_i[7:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q  <= '0;
            exit_q   <= '0;
            halt_q   <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cycle_q  <= cycle_d;
            exit_q   <= exit_d;
            halt_q   <= halt_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
    assign con_valid_o = !empty;
    assign con_data_o  = empty ? 8'h00 : con_buf_q[rd_ptr_q];
    assign halt_o      = halt_q;
    assign exit_code_o = exit_q;
    assign err_o       = err_q;
endmodule
